decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Clocked, parametrised LEGv8 instruction-decode stage: register file with write-back bypass, operand select (Reg2Loc), immediate sign-extension per format, and the ID/EX pipeline register.
- Sits between fetch and execution.
- Owns load-use hazard detection: stalls fetch and inserts a bubble.
- Honours downstream stall/flush and keeps a saturating hazard-stall counter.

Parameters:
DATA_W, 64, register/operand width
NREGS, 32, register count; index NREGS-1 is XZR (reads 0, writes ignored)
REG_AW, 5, register index width (2**REG_AW >= NREGS)
ADDR_W, 64, PC width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_valid  in  1  fetch offers instruction
if_instr  in  32  instruction word
if_pc  in  ADDR_W  its address
if_ready  out  1  stage accepts offered instruction this cycle
ex_stall  in  1  execution cannot accept; hold ID/EX
ex_flush  in  1  branch taken; kill ID/EX and offered instruction
wb_en  in  1  write-back enable
wb_reg  in  REG_AW  write-back index
wb_data  in  DATA_W  write-back value
id_valid  out  1  ID/EX holds a live instruction
id_pc  out  ADDR_W  registered PC
id_instr  out  32  registered instruction
id_data1  out  DATA_W  Rn operand
id_data2  out  DATA_W  Rm or Rt operand
id_imm  out  DATA_W  extended immediate
id_rd  out  REG_AW  instr[4:0]
id_memread  out  1  registered instruction is LDUR
stall_cnt  out  CNT_W  hazard-stall cycles, saturating

Behaviour:
- Reset (the cycle rst is sampled high):
  - All registers and all outputs clear to 0.
  - id_valid=0, stall_cnt=0.
  - Reset mid-stall drops the pending instruction.
- Register file writes:
  - Write happens on the clk edge when wb_en=1 and wb_reg != NREGS-1.
  - Index >= NREGS is ignored.
- Register file reads (combinational on if_instr):
  - src1 = instr[9:5].
  - src2 = instr[4:0] if Reg2Loc, else instr[20:16].
  - Bypass: if wb_en and wb_reg == src and src != NREGS-1, the read value is wb_data in the same cycle.
  - XZR always reads 0.
- Reg2Loc = 1 for:
  - STUR (instr[31:21]=11111000000)
  - CBZ (instr[31:24]=10110100)
  - CBNZ (instr[31:24]=10110101)
- id_memread = 1 for LDUR (instr[31:21]=11111000010).
- Immediate, selected on opcode:
  - B/BL (instr[30:26]=00101): sext instr[25:0].
  - CB: sext instr[23:5].
  - D-type loads/stores: sext instr[20:12].
  - ADDI/SUBI (instr[31:22] in {1001000100, 1101000100}): zext instr[21:10].
  - Otherwise: sext instr[31:0].
- Hazard = id_valid & id_memread & if_valid & id_rd != NREGS-1 & (id_rd == src1 | id_rd == src2).
  - src2 counts only when the instruction reads it: R-type, STUR, CB.
- if_ready = ex_flush | (!ex_stall & !hazard).
- ID/EX update, priority order:
  1. rst: clear.
  2. ex_flush: id_valid <= 0; offered instruction consumed and dropped.
  3. ex_stall: hold all ID/EX outputs unchanged; offered instruction not consumed.
  4. hazard: id_valid <= 0 (bubble); other fields may change; one cycle later the load has left and the instruction is accepted.
  5. Otherwise: load all fields; id_valid <= if_valid.
- Latency: instruction accepted at edge N appears on id_* after edge N; one cycle.
- stall_cnt:
  - Increments on each cycle with hazard & !ex_stall & !ex_flush.
  - Saturates at 2**CNT_W-1; no wrap.
- Simultaneous cases:
  - Write-back to a register being read in the same cycle yields wb_data (bypass).
  - Flush and hazard together: flush wins; no count.

Test Plan:
- Reset, then write X3=0x1234 via wb → ADD X1,X3,X2 with X2=5 offered → next cycle id_data1=0x1234, id_data2=5, id_valid=1, id_rd=1.
- wb_en writing X7=0xAA in the same cycle STUR X7,[X2,#-8] is offered → id_data2=0xAA (bypass); id_imm=0xFFFF_FFFF_FFFF_FFF8.
- LDUR X4,[X1,#0] followed by ADD X5,X4,X4:
  - if_ready=0 for one cycle, then id_valid=0 bubble.
  - ADD enters next cycle.
  - stall_cnt=1.
- Write to X31 with 0xFF, then read X31 → 0; CBZ with imm19 = -1 → id_imm all ones.
- ex_stall held 3 cycles with a valid instruction in ID/EX → outputs unchanged, if_ready=0; then ex_flush during a hazard → id_valid=0, if_ready=1, stall_cnt unchanged.
- CNT_W=2 with 5 consecutive hazards → stall_cnt saturates at 3; assert rst mid-stall → next cycle all outputs 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: groups the fetch, write-back, downstream-control and
// ID/EX signals of the LEGv8 decode stage.
//   master : driven by the environment (fetch / execute / write-back side)
//   slave  : used by decode_stage
// Fetch      : if_valid, if_instr, if_pc -> ; <- if_ready
// Downstream : ex_stall, ex_flush ->
// Write-back : wb_en, wb_reg, wb_data ->
// ID/EX      : <- id_valid, id_pc, id_instr, id_data1, id_data2, id_imm,
//                 id_rd, id_memread, stall_cnt
// The parameters must match the ones given to the decode_stage instance.
interface decode_stage_if #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_ready;
  logic              ex_stall;
  logic              ex_flush;
  logic              wb_en;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [31:0]       id_instr;
  logic [DATA_W-1:0] id_data1;
  logic [DATA_W-1:0] id_data2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rd;
  logic              id_memread;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output if_valid, if_instr, if_pc, ex_stall, ex_flush, wb_en, wb_reg, wb_data,
    input  if_ready, id_valid, id_pc, id_instr, id_data1, id_data2, id_imm,
           id_rd, id_memread, stall_cnt
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_stall, ex_flush, wb_en, wb_reg, wb_data,
    output if_ready, id_valid, id_pc, id_instr, id_data1, id_data2, id_imm,
           id_rd, id_memread, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: LEGv8 instruction-decode stage.
// Register file with same-cycle write-back bypass, Reg2Loc operand select,
// per-format immediate extension, load-use hazard detection (stalls fetch
// and inserts a bubble), ID/EX pipeline register honouring downstream
// stall/flush, and a saturating hazard-stall counter.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : decode_stage_if.slave (fetch, write-back, ex control, ID/EX outputs)
module decode_stage #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 32,
  parameter int REG_AW = 5,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  localparam logic [REG_AW-1:0] XZR     = REG_AW'(NREGS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs_r [NREGS];

  logic              id_valid_r;
  logic [ADDR_W-1:0] id_pc_r;
  logic [31:0]       id_instr_r;
  logic [DATA_W-1:0] id_data1_r;
  logic [DATA_W-1:0] id_data2_r;
  logic [DATA_W-1:0] id_imm_r;
  logic [REG_AW-1:0] id_rd_r;
  logic              id_memread_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic              is_stur_s, is_ldur_s, is_cb_s, is_b_s, is_addsubi_s, is_rtype_s;
  logic              uses_src2_s, hazard_s, if_ready_s;
  logic [REG_AW-1:0] src1_s, src2_s;
  logic [DATA_W-1:0] data1_s, data2_s, imm_s;

  // Indices at or above NREGS do not name a register (only possible when
  // 2**REG_AW > NREGS); widened by one bit so the compare is never constant.
  function automatic logic in_range(input logic [REG_AW-1:0] idx);
    return ({1'b0, idx} < (REG_AW + 1)'(NREGS));
  endfunction

  // Operand read: XZR and non-existent registers read 0; a write-back to the
  // same register in this cycle is forwarded ahead of the stored value.
  function automatic logic [DATA_W-1:0] read_operand(
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              w_en,
    input logic [REG_AW-1:0] w_reg,
    input logic [DATA_W-1:0] w_data
  );
    logic [DATA_W-1:0] val;
    if ((idx == XZR) || !in_range(idx)) begin
      val = {DATA_W{1'b0}};
    end else if (w_en && (w_reg == idx)) begin
      val = w_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Register file storage: cleared by reset, written from write-back except XZR
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (bus.wb_en && (bus.wb_reg != XZR) && in_range(bus.wb_reg)) begin
      regs_r[bus.wb_reg] <= bus.wb_data;
    end
  end

  // Opcode decode, operand selection, immediate extension and hazard detection
  always_comb begin
    is_stur_s    = (bus.if_instr[31:21] == 11'b11111000000);
    is_ldur_s    = (bus.if_instr[31:21] == 11'b11111000010);
    is_cb_s      = (bus.if_instr[31:25] == 7'b1011010);   // CBZ and CBNZ
    is_b_s       = (bus.if_instr[30:26] == 5'b00101);     // B and BL
    is_addsubi_s = (bus.if_instr[31:22] == 10'b1001000100) ||
                   (bus.if_instr[31:22] == 10'b1101000100);
    // Register-register ALU ops (ADD/SUB/AND/ORR/EOR families).
    is_rtype_s   = (bus.if_instr[28:25] == 4'b0101);
    uses_src2_s  = is_rtype_s | is_stur_s | is_cb_s;

    src1_s = REG_AW'(bus.if_instr[9:5]);
    // Reg2Loc: stores and compare-branches read Rt from [4:0] instead of Rm.
    if (is_stur_s || is_cb_s) begin
      src2_s = REG_AW'(bus.if_instr[4:0]);
    end else begin
      src2_s = REG_AW'(bus.if_instr[20:16]);
    end

    data1_s = read_operand(src1_s, regs_r[src1_s], bus.wb_en, bus.wb_reg, bus.wb_data);
    data2_s = read_operand(src2_s, regs_r[src2_s], bus.wb_en, bus.wb_reg, bus.wb_data);

    if (is_b_s) begin
      imm_s = DATA_W'($signed(bus.if_instr[25:0]));
    end else if (is_cb_s) begin
      imm_s = DATA_W'($signed(bus.if_instr[23:5]));
    end else if (is_stur_s || is_ldur_s) begin
      imm_s = DATA_W'($signed(bus.if_instr[20:12]));
    end else if (is_addsubi_s) begin
      imm_s = DATA_W'(bus.if_instr[21:10]);
    end else begin
      imm_s = DATA_W'($signed(bus.if_instr[31:0]));
    end

    // Load-use: the load in ID/EX writes a register this instruction reads.
    hazard_s = id_valid_r & id_memread_r & bus.if_valid & (id_rd_r != XZR) &
               ((id_rd_r == src1_s) | (uses_src2_s & (id_rd_r == src2_s)));

    // A flush consumes (and drops) whatever is offered, so fetch may advance.
    if (rst) begin
      if_ready_s = 1'b0;
    end else begin
      if_ready_s = bus.ex_flush | (!bus.ex_stall & !hazard_s);
    end
  end

  // ID/EX register: reset, then flush, then hold on stall, then bubble, then load
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_r   <= 1'b0;
      id_pc_r      <= {ADDR_W{1'b0}};
      id_instr_r   <= 32'h0000_0000;
      id_data1_r   <= {DATA_W{1'b0}};
      id_data2_r   <= {DATA_W{1'b0}};
      id_imm_r     <= {DATA_W{1'b0}};
      id_rd_r      <= {REG_AW{1'b0}};
      id_memread_r <= 1'b0;
    end else if (bus.ex_flush) begin
      id_valid_r <= 1'b0;
    end else if (bus.ex_stall) begin
      id_valid_r <= id_valid_r;
    end else if (hazard_s) begin
      id_valid_r <= 1'b0;
    end else begin
      id_valid_r   <= bus.if_valid;
      id_pc_r      <= bus.if_pc;
      id_instr_r   <= bus.if_instr;
      id_data1_r   <= data1_s;
      id_data2_r   <= data2_s;
      id_imm_r     <= imm_s;
      id_rd_r      <= REG_AW'(bus.if_instr[4:0]);
      id_memread_r <= is_ldur_s;
    end
  end

  // Hazard-stall counter: counts real bubble cycles, sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (hazard_s && !bus.ex_stall && !bus.ex_flush && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

  assign bus.if_ready   = if_ready_s;
  assign bus.id_valid   = id_valid_r;
  assign bus.id_pc      = id_pc_r;
  assign bus.id_instr   = id_instr_r;
  assign bus.id_data1   = id_data1_r;
  assign bus.id_data2   = id_data2_r;
  assign bus.id_imm     = id_imm_r;
  assign bus.id_rd      = id_rd_r;
  assign bus.id_memread = id_memread_r;
  assign bus.stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
// Expected ID/EX contents are pushed to a scoreboard queue when an
// instruction is offered and accepted, and popped when it reaches ID/EX.
// The stall counter is built 2 bits wide so saturation is reachable.
module tb_decode_stage;

  localparam int DATA_W = 64;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;
  localparam int ADDR_W = 64;
  localparam int CNT_W  = 2;

  localparam logic [31:0] ADD_1_3_2 = 32'h8B02_0061;  // ADD  X1,X3,X2
  localparam logic [31:0] STUR_7    = 32'hF81F_8047;  // STUR X7,[X2,#-8]
  localparam logic [31:0] LDUR_4    = 32'hF840_0024;  // LDUR X4,[X1,#0]
  localparam logic [31:0] ADD_5_4_4 = 32'h8B04_0085;  // ADD  X5,X4,X4
  localparam logic [31:0] CBZ_31_M1 = 32'hB4FF_FFFF;  // CBZ  X31,#-1

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        mr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  decode_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  decode_stage #(
    .DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [31:0] instr);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    bus.if_instr = instr;
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] instr, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] imm, input logic [4:0] rd,
                          input logic mr);
    exp_t e;
    e.pc = pc; e.instr = instr; e.d1 = d1; e.d2 = d2; e.imm = imm; e.rd = rd; e.mr = mr;
    sb.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    chk({tag, ".valid"}, 64'(bus.id_valid), 64'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc"},      64'(bus.id_pc),      e.pc);
      chk({tag, ".instr"},   64'(bus.id_instr),   64'(e.instr));
      chk({tag, ".data1"},   bus.id_data1,        e.d1);
      chk({tag, ".data2"},   bus.id_data2,        e.d2);
      chk({tag, ".imm"},     bus.id_imm,          e.imm);
      chk({tag, ".rd"},      64'(bus.id_rd),      64'(e.rd));
      chk({tag, ".memread"}, 64'(bus.id_memread), 64'(e.mr));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valid"},   64'(bus.id_valid),   64'd0);
    chk({tag, ".pc"},      64'(bus.id_pc),      64'd0);
    chk({tag, ".instr"},   64'(bus.id_instr),   64'd0);
    chk({tag, ".data1"},   bus.id_data1,        64'd0);
    chk({tag, ".data2"},   bus.id_data2,        64'd0);
    chk({tag, ".imm"},     bus.id_imm,          64'd0);
    chk({tag, ".rd"},      64'(bus.id_rd),      64'd0);
    chk({tag, ".memread"}, 64'(bus.id_memread), 64'd0);
    chk({tag, ".cnt"},     64'(bus.stall_cnt),  64'd0);
    chk({tag, ".ready"},   64'(bus.if_ready),   64'd0);
  endtask

  initial begin
    int exp_cnt;
    rst          = 1'b1;
    bus.if_valid = 1'b0;
    bus.if_instr = 32'h0000_0000;
    bus.if_pc    = 64'd0;
    bus.ex_stall = 1'b0;
    bus.ex_flush = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_reg   = 5'd0;
    bus.wb_data  = 64'd0;

    // Reset state (rst still high: if_ready also 0)
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Write X2=5 and X3=0x1234, then ADD X1,X3,X2
    bus.wb_en = 1'b1; bus.wb_reg = 5'd2; bus.wb_data = 64'd5;
    tick();
    bus.wb_reg = 5'd3; bus.wb_data = 64'h1234;
    tick();
    bus.wb_en = 1'b0;
    offer(64'h100, ADD_1_3_2);
    #1 chk("add.ready", 64'(bus.if_ready), 64'd1);
    push_exp(64'h100, ADD_1_3_2, 64'h1234, 64'd5, 64'hFFFF_FFFF_8B02_0061, 5'd1, 1'b0);
    tick();
    check_pop("add");

    // STUR X7 with X7=0xAA written back in the same cycle (bypass)
    offer(64'h104, STUR_7);
    bus.wb_en = 1'b1; bus.wb_reg = 5'd7; bus.wb_data = 64'hAA;
    push_exp(64'h104, STUR_7, 64'd5, 64'hAA, 64'hFFFF_FFFF_FFFF_FFF8, 5'd7, 1'b0);
    tick();
    bus.wb_en = 1'b0;
    check_pop("stur");

    // LDUR X4 then dependent ADD X5,X4,X4: one bubble
    offer(64'h108, LDUR_4);
    push_exp(64'h108, LDUR_4, 64'd0, 64'd0, 64'd0, 5'd4, 1'b1);
    tick();
    check_pop("ldur");
    offer(64'h10C, ADD_5_4_4);
    #1 chk("hazard.ready", 64'(bus.if_ready), 64'd0);
    tick();
    chk("bubble.valid", 64'(bus.id_valid), 64'd0);
    chk("bubble.cnt", 64'(bus.stall_cnt), 64'd1);
    bus.wb_en = 1'b1; bus.wb_reg = 5'd4; bus.wb_data = 64'h77;
    #1 chk("after_bubble.ready", 64'(bus.if_ready), 64'd1);
    push_exp(64'h10C, ADD_5_4_4, 64'h77, 64'h77, 64'hFFFF_FFFF_8B04_0085, 5'd5, 1'b0);
    tick();
    bus.wb_en = 1'b0;
    check_pop("add_dep");
    chk("add_dep.cnt", 64'(bus.stall_cnt), 64'd1);

    // XZR: write ignored, reads 0 even with a same-cycle write; CBZ imm19=-1
    bus.if_valid = 1'b0;
    bus.wb_en = 1'b1; bus.wb_reg = 5'd31; bus.wb_data = 64'hFF;
    tick();
    offer(64'h114, CBZ_31_M1);
    push_exp(64'h114, CBZ_31_M1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1'b0);
    tick();
    bus.wb_en = 1'b0;
    check_pop("cbz");

    // Downstream stall for 3 cycles: ID/EX held, offered ADD not accepted
    offer(64'h118, ADD_1_3_2);
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.ready", 64'(bus.if_ready), 64'd0);
      tick();
      chk("stall.valid", 64'(bus.id_valid), 64'd1);
      chk("stall.pc", 64'(bus.id_pc), 64'h114);
      chk("stall.instr", 64'(bus.id_instr), 64'(CBZ_31_M1));
      chk("stall.imm", bus.id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    bus.ex_stall = 1'b0;
    push_exp(64'h118, ADD_1_3_2, 64'h1234, 64'd5, 64'hFFFF_FFFF_8B02_0061, 5'd1, 1'b0);
    tick();
    check_pop("post_stall");

    // Flush during a hazard: flush wins, no count
    offer(64'h11C, LDUR_4);
    push_exp(64'h11C, LDUR_4, 64'd0, 64'd0, 64'd0, 5'd4, 1'b1);
    tick();
    check_pop("ldur2");
    offer(64'h120, ADD_5_4_4);
    bus.ex_flush = 1'b1;
    #1 chk("flush.ready", 64'(bus.if_ready), 64'd1);
    tick();
    bus.ex_flush = 1'b0;
    chk("flush.valid", 64'(bus.id_valid), 64'd0);
    chk("flush.cnt", 64'(bus.stall_cnt), 64'd1);

    // Five more hazards: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      offer(64'h200 + 64'(8 * i), LDUR_4);
      push_exp(64'h200 + 64'(8 * i), LDUR_4, 64'd0, 64'd0, 64'd0, 5'd4, 1'b1);
      tick();
      check_pop("sat.ldur");
      offer(64'h204 + 64'(8 * i), ADD_5_4_4);
      #1 chk("sat.ready", 64'(bus.if_ready), 64'd0);
      tick();
      chk("sat.valid", 64'(bus.id_valid), 64'd0);
      exp_cnt = (i + 2 > 3) ? 3 : i + 2;
      chk("sat.cnt", 64'(bus.stall_cnt), 64'(exp_cnt));
    end

    // Reset in the middle of a load-use stall
    offer(64'h300, LDUR_4);
    push_exp(64'h300, LDUR_4, 64'd0, 64'd0, 64'd0, 5'd4, 1'b1);
    tick();
    check_pop("rst.ldur");
    offer(64'h304, ADD_5_4_4);
    #1 chk("rst.hazard_ready", 64'(bus.if_ready), 64'd0);
    rst = 1'b1;
    tick();
    check_all_zero("midstall_reset");
    rst = 1'b0;
    bus.if_valid = 1'b0;
    tick();
    chk("post_reset.valid", 64'(bus.id_valid), 64'd0);

    // Register file cleared by reset: X3 and X2 read 0
    offer(64'h400, ADD_1_3_2);
    push_exp(64'h400, ADD_1_3_2, 64'd0, 64'd0, 64'hFFFF_FFFF_8B02_0061, 5'd1, 1'b0);
    tick();
    bus.if_valid = 1'b0;
    check_pop("rf_cleared");

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
